// File: rtl/adc0804_sampler.sv
// Periodic conversion controller for an 8-bit parallel ADC (ADC0804-style CS/WR/RD/INTR handshake).
// Emits each captured result as a registered sample with a one-cycle valid strobe.
module adc0804_sampler #(
  parameter int unsigned SAMPLE_DIV     = 250_000,
  parameter int unsigned WR_CYCLES      = 4,
  parameter int unsigned RD_CYCLES      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear_err,
  input  logic [7:0] adc_data,
  input  logic       adc_intr_n,
  output logic       adc_cs_n,
  output logic       adc_wr_n,
  output logic       adc_rd_n,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int unsigned TW            = $clog2(SAMPLE_DIV);
  localparam int unsigned CW            = $clog2(TIMEOUT_CYCLES + WR_CYCLES + RD_CYCLES + 1);
  localparam int unsigned IGNORE_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_INTR,
    READ,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] step;
  logic [1:0]    intr_sync;
  logic          intr_synced;
  logic          tick;

  // Two-flop synchronizer for the asynchronous INTR pin; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intr_sync <= 2'b11;
    end else begin
      intr_sync <= {intr_sync[0], adc_intr_n};
    end
  end

  assign intr_synced = intr_sync[1];

  // Sample-rate divider; held at zero while disabled so re-enabling restarts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TW'(SAMPLE_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));

  // Handshake sequencer; error flags are written last so a same-cycle set beats clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= '0;
      adc_cs_n     <= 1'b1;
      adc_wr_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (clear_err) begin
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            state    <= START;
            step     <= '0;
            adc_cs_n <= 1'b0;
            adc_wr_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (step == CW'(WR_CYCLES - 1)) begin
            state    <= WAIT_INTR;
            step     <= '0;
            adc_cs_n <= 1'b1;
            adc_wr_n <= 1'b1;
          end else begin
            step <= step + CW'(1);
          end
        end
        WAIT_INTR: begin
          // The first synchronizer outputs may still reflect INTR from before this conversion.
          if ((step >= CW'(IGNORE_CYCLES)) && !intr_synced) begin
            state    <= READ;
            step     <= '0;
            adc_cs_n <= 1'b0;
            adc_rd_n <= 1'b0;
          end else if (step == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            step        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            step <= step + CW'(1);
          end
        end
        READ: begin
          if (step == CW'(RD_CYCLES - 1)) begin
            state        <= DONE;
            step         <= '0;
            sample       <= adc_data;
            sample_valid <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
          end else begin
            step <= step + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          step     <= '0;
          adc_cs_n <= 1'b1;
          adc_wr_n <= 1'b1;
          adc_rd_n <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc0804_sampler.sv
// Scoreboard bench for adc0804_sampler with a behavioural ADC0804 model.
// Expected samples are queued by the stimulus; a monitor pops them on sample_valid.
module tb_adc0804_sampler;

  localparam int unsigned DIV = 64;
  localparam int unsigned TMO = 5_000;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       clear_err;
  logic [7:0] adc_data;
  logic       adc_intr_n;
  logic       adc_cs_n;
  logic       adc_wr_n;
  logic       adc_rd_n;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       timeout_err;
  logic       overrun;

  adc0804_sampler #(
    .SAMPLE_DIV    (DIV),
    .WR_CYCLES     (4),
    .RD_CYCLES     (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear_err   (clear_err),
    .adc_data    (adc_data),
    .adc_intr_n  (adc_intr_n),
    .adc_cs_n    (adc_cs_n),
    .adc_wr_n    (adc_wr_n),
    .adc_rd_n    (adc_rd_n),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model: mode 0 = INTR falls intr_delay cycles after WR rises, 1 = INTR never falls, 2 = INTR stuck low.
  int mode       = 0;
  int intr_delay = 20;
  int cd         = 0;
  logic m_prev_wr = 1'b1;

  always @(negedge clk) begin
    if (mode == 2) begin
      adc_intr_n = 1'b0;
    end else if (mode == 1) begin
      adc_intr_n = 1'b1;
      cd = 0;
    end else begin
      if (!adc_wr_n || !adc_rd_n) adc_intr_n = 1'b1;
      if (!m_prev_wr && adc_wr_n) begin
        cd = intr_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) adc_intr_n = 1'b0;
      end
    end
    m_prev_wr = adc_wr_n;
  end

  // Monitor: scoreboard pops, pulse width, strobe invariants and strobe timing capture.
  logic prev_valid = 1'b0;
  logic prev_wr = 1'b1;
  logic prev_rd = 1'b1;
  logic prev_cs = 1'b1;
  int   inv_bad = 0;
  int   wr_run = 0, rd_run = 0, wr_len = 0, rd_len = 0;
  int   start_cyc = 0, wr_rise_cyc = 0, rd_fall_cyc = 0, cs_falls = 0;

  always @(negedge clk) begin
    if (sample_valid) begin
      if (prev_valid) begin
        tests++;
        fails++;
        $display("FAIL valid_width: sample_valid high 2+ cycles (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: sample %0h with empty scoreboard (cycle %0d)", sample, cyc);
      end else begin
        check("sample", 32'(sample), 32'(sb.pop_front()));
      end
    end
    prev_valid = sample_valid;
    if ((!adc_wr_n && !adc_rd_n) || (adc_cs_n != (adc_wr_n & adc_rd_n))) inv_bad++;
    if (prev_wr && !adc_wr_n) start_cyc = cyc;
    if (prev_rd && !adc_rd_n) rd_fall_cyc = cyc;
    if (prev_cs && !adc_cs_n) cs_falls++;
    if (!adc_wr_n) wr_run++;
    else if (wr_run > 0) begin
      wr_len = wr_run;
      wr_run = 0;
      wr_rise_cyc = cyc;
    end
    if (!adc_rd_n) rd_run++;
    else if (rd_run > 0) begin
      rd_len = rd_run;
      rd_run = 0;
    end
    prev_wr = adc_wr_n;
    prev_rd = adc_rd_n;
    prev_cs = adc_cs_n;
  end

  task automatic wait_valid(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: no sample_valid within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  // which: 0 = wr_n low, 1 = rd_n low, 2 = timeout_err high
  task automatic wait_for(input int which, input int budget, input string name, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((which == 0 && !adc_wr_n) || (which == 1 && !adc_rd_n) || (which == 2 && timeout_err)) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  int t_rel, t_at, s_a, s_b, falls0;

  initial begin
    reset_n    = 1'b1;
    enable     = 1'b1;
    clear_err  = 1'b0;
    adc_data   = 8'hA5;
    adc_intr_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_wr_n", 32'(adc_wr_n), 32'd1);
    check("rst_rd_n", 32'(adc_rd_n), 32'd1);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Normal periodic conversions, INTR 20 cycles after WR rises.
    sb.push_back(8'hA5);
    reset_n = 1'b1;
    t_rel = cyc;
    wait_for(0, 200, "first_start", t_at);
    check("first_start_delay", 32'(t_at - t_rel), 32'(DIV));
    wait_valid(200, "conv_a");
    check("wr_low_len", 32'(wr_len), 32'd4);
    check("rd_low_len", 32'(rd_len), 32'd8);
    s_a = start_cyc;
    adc_data = 8'h5A;
    sb.push_back(8'h5A);
    wait_valid(200, "conv_b");
    s_b = start_cyc;
    check("start_period", 32'(s_b - s_a), 32'(DIV));
    check("rd_low_len_b", 32'(rd_len), 32'd8);
    check("no_overrun", 32'(overrun), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    // Timeout: INTR never arrives.
    mode = 1;
    wait_for(2, TMO + 300, "timeout", t_at);
    check("timeout_wait_len", 32'(t_at - wr_rise_cyc), 32'(TMO));
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_sample_kept", 32'(sample), 32'h5A);
    mode = 0;
    adc_data = 8'h77;
    sb.push_back(8'h77);
    wait_valid(200, "after_timeout");
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    check("overrun_in_wait", 32'(overrun), 32'd1);
    pulse_clear();
    check("clear_timeout", 32'(timeout_err), 32'd0);
    check("clear_overrun", 32'(overrun), 32'd0);

    // Slow ADC: conversion outlasts the sample period.
    intr_delay = 80;
    adc_data = 8'h3C;
    sb.push_back(8'h3C);
    wait_valid(400, "slow_a");
    s_a = start_cyc;
    adc_data = 8'hC3;
    sb.push_back(8'hC3);
    wait_valid(400, "slow_b");
    s_b = start_cyc;
    check("slow_overrun", 32'(overrun), 32'd1);
    check("slow_period", 32'(s_b - s_a), 32'(2 * DIV));
    pulse_clear();
    check("slow_clear", 32'(overrun), 32'd0);

    // Stale INTR held low: READ only after the ignore window.
    intr_delay = 20;
    mode = 2;
    adc_data = 8'h96;
    sb.push_back(8'h96);
    wait_valid(200, "stale");
    check("stale_wait_len", 32'(rd_fall_cyc - wr_rise_cyc), 32'd4);
    mode = 0;

    // Enable dropped mid-READ: finish, then stay quiet until re-enabled.
    adc_data = 8'hE1;
    sb.push_back(8'hE1);
    wait_for(1, 200, "en_rd_low", t_at);
    enable = 1'b0;
    wait_valid(50, "en_finish");
    falls0 = cs_falls;
    repeat (200) @(negedge clk);
    check("disabled_no_cs", 32'(cs_falls), 32'(falls0));
    check("disabled_busy", 32'(busy), 32'd0);
    adc_data = 8'h1E;
    sb.push_back(8'h1E);
    enable = 1'b1;
    t_rel = cyc;
    wait_for(0, 200, "reenable_start", t_at);
    check("reenable_delay", 32'(t_at - t_rel), 32'(DIV));
    wait_valid(200, "reenable_conv");

    // Asynchronous reset mid-READ.
    adc_data = 8'h4B;
    wait_for(1, 200, "rst_rd_low", t_at);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(adc_cs_n), 32'd1);
    check("arst_rd_n", 32'(adc_rd_n), 32'd1);
    check("arst_wr_n", 32'(adc_wr_n), 32'd1);
    check("arst_sample", 32'(sample), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    sb.push_back(8'h4B);
    reset_n = 1'b1;
    t_rel = cyc;
    wait_for(0, 200, "post_rst_start", t_at);
    check("post_rst_delay", 32'(t_at - t_rel), 32'(DIV));
    wait_valid(200, "post_rst_conv");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("strobe_invariant", 32'(inv_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
